// File: rtl/io_pkg.sv
// Shared definitions for the I/O unit: FSM states, data width and IOsel encodings.
package io_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned DATA_W = 32;

    localparam logic IOSEL_IN  = 1'b1;
    localparam logic IOSEL_OUT = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StDone
    } io_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a saturating stable-level debouncer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles where the synchronized input disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/io_unit.sv
// CPU I/O unit: IN handshake driven by a debounced confirm button, and an OUT register.
module io_unit import io_pkg::*; #(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SW_WIDTH        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                IOE,
    input  logic                IOsel,
    input  logic                stall,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_btn,
    output logic                cpu_stall,
    output logic [DATA_W-1:0]   in_data,
    output logic                in_we,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid
);

    io_state_e state_q, state_d;
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
    logic [DATA_W-1:0] in_data_q, in_data_d, out_data_q, out_data_d, sw_ext;
    logic out_valid_q, out_valid_d;
    logic btn_level, btn_prev_q, btn_rise, btn_fall;
    logic in_req, out_req, in_active;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock(clock),
        .reset(reset),
        .raw  (confirm_btn),
        .level(btn_level)
    );

    assign in_active = IOE && (IOsel == IOSEL_IN);
    assign in_req    = in_active && stall;
    assign out_req   = IOE && (IOsel == IOSEL_OUT);
    // Edge detection means a press already held at IN start never counts.
    assign btn_rise  = btn_level && !btn_prev_q;
    assign btn_fall  = !btn_level && btn_prev_q;

    always_comb begin
        state_d     = state_q;
        in_data_d   = in_data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_we       = 1'b0;
        cpu_stall   = 1'b0;
        sw_ext      = '0;
        sw_ext[SW_WIDTH-1:0] = sw_s2_q;
        unique case (state_q)
            StIdle: begin
                if (in_req) begin
                    cpu_stall = 1'b1;
                    state_d   = StWaitPress;
                end else if (out_req) begin
                    out_data_d  = rs_data;
                    out_valid_d = 1'b1;
                end
            end
            StWaitPress: begin
                cpu_stall = 1'b1;
                if (!in_active) begin
                    state_d = StIdle;
                end else if (btn_rise) begin
                    in_data_d = sw_ext;
                    state_d   = StWaitRelease;
                end
            end
            StWaitRelease: begin
                cpu_stall = 1'b1;
                if (!in_active) begin
                    state_d = StIdle;
                end else if (btn_fall) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                in_we   = 1'b1;
                state_d = StIdle;
            end
        endcase
        // The IN decode term is combinational, so mask it while reset is held.
        if (reset) begin
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_prev_q  <= 1'b0;
            in_data_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_s1_q     <= switches;
            sw_s2_q     <= sw_s1_q;
            btn_prev_q  <= btn_level;
            in_data_q   <= in_data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_data   = in_data_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
